// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready pipeline stage: registered out_data and in_ready, with a skid slot.
// Optional backpressure counter on stall_cnt is compiled in when PIPE_STALL_CNT_EN is defined.
module pipe_skid_stage #(
    parameter int unsigned  W         = 32,
    parameter logic [W-1:0] RST_VAL   = W'(32'h0000_3000),
    parameter logic [W-1:0] FLUSH_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           acc, dep;

    assign acc = in_valid & in_ready_q;
    assign dep = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = FLUSH_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (acc && dep) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (dep) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (dep) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Handshake flags are registered copies of the next occupancy.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= RST_VAL;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every cycle plus directed literals.
// A W=8 instance runs a random-handshake stream against the same kind of model.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic        in_valid8, out_ready8;
    logic [7:0]  in_data8;
    logic        in_ready8, out_valid8;
    logic [7:0]  out_data8;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt8;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          chk_en   = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    pipe_skid_stage #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .flush(1'b0), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_data(out_data8)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt8)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of held beats, oldest first; last departed value shown when empty.
    logic [31:0] q32[$];
    logic [31:0] last32;
    logic [7:0]  q8[$];
    logic [7:0]  last8;
    logic [15:0] cnt32, cnt8;

    always @(posedge clk) begin
        bit a, d;
        if (!rst_n) begin
            q32.delete(); last32 = 32'h0000_3000; cnt32 = 16'd0;
            q8.delete();  last8  = 8'h00;         cnt8  = 16'd0;
            chk_en = 1'b1;
        end else begin
            if (q32.size() > 0 && !out_ready && cnt32 != 16'hFFFF) cnt32++;
            if (flush) begin
                q32.delete(); last32 = 32'h0;
            end else begin
                a = in_valid && (q32.size() < 2);
                d = (q32.size() > 0) && out_ready;
                if (d) last32 = q32.pop_front();
                if (a) q32.push_back(in_data);
            end
            if (q8.size() > 0 && !out_ready8 && cnt8 != 16'hFFFF) cnt8++;
            a = in_valid8 && (q8.size() < 2);
            d = (q8.size() > 0) && out_ready8;
            if (d) last8 = q8.pop_front();
            if (a) q8.push_back(in_data8);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_valid", 64'(out_valid), 64'(q32.size() != 0));
            chk("m_in_ready",  64'(in_ready),  64'(q32.size() < 2));
            if (q32.size() != 0) chk("m_out_data", 64'(out_data), 64'(q32[0]));
            else                 chk("m_out_data", 64'(out_data), 64'(last32));
            chk("m8_out_valid", 64'(out_valid8), 64'(q8.size() != 0));
            chk("m8_in_ready",  64'(in_ready8),  64'(q8.size() < 2));
            if (q8.size() != 0) chk("m8_out_data", 64'(out_data8), 64'(q8[0]));
            else                chk("m8_out_data", 64'(out_data8), 64'(last8));
`ifdef PIPE_STALL_CNT_EN
            chk("m_stall_cnt",  64'(stall_cnt),  64'(cnt32));
            chk("m8_stall_cnt", 64'(stall_cnt8), 64'(cnt8));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] dat, input logic r);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(v));
        chk({tag, "_out_data"},  64'(out_data),  64'(dat));
        chk({tag, "_in_ready"},  64'(in_ready),  64'(r));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
        step(); step();
        expect_out("reset", 1'b0, 32'h0000_3000, 1'b1);

        // Streaming at full rate, first beat accepted on the first edge after release.
        rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h11;
        step(); expect_out("s1", 1'b1, 32'h11, 1'b1);
        in_data = 32'h22;
        step(); expect_out("s2", 1'b1, 32'h22, 1'b1);
        in_data = 32'h33;
        step(); expect_out("s3", 1'b1, 32'h33, 1'b1);
        in_valid = 1'b0;
        step(); expect_out("s_drain", 1'b0, 32'h33, 1'b1);

        // Backpressure fills the skid slot, then drains in order.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step(); expect_out("bp1", 1'b1, 32'hA, 1'b1);
        in_data = 32'hB;
        step(); expect_out("bp_full", 1'b1, 32'hA, 1'b0);
        step(); expect_out("bp_hold", 1'b1, 32'hA, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        step(); expect_out("bp_dep1", 1'b1, 32'hB, 1'b1);
        step(); expect_out("bp_dep2", 1'b0, 32'hB, 1'b1);

        // Flush from FULL drops the held beats and the beat offered alongside it.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step(); expect_out("fl_full", 1'b1, 32'hA, 1'b0);
        flush = 1'b1; in_data = 32'hC;
        step(); expect_out("flush", 1'b0, 32'h0, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); expect_out("fl_after", 1'b0, 32'h0, 1'b1);

        // Reset while FULL discards everything.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        rst_n = 1'b0; in_valid = 1'b0;
        step(); expect_out("rst_mid", 1'b0, 32'h0000_3000, 1'b1);
        rst_n = 1'b1; out_ready = 1'b1;
        step(); expect_out("rst_after", 1'b0, 32'h0000_3000, 1'b1);

`ifdef PIPE_STALL_CNT_EN
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        step(); chk("stall_0", 64'(stall_cnt), 64'd0);
        in_valid = 1'b0;
        step(); chk("stall_1", 64'(stall_cnt), 64'd1);
        step(); chk("stall_2", 64'(stall_cnt), 64'd2);
        for (int unsigned i = 0; i < 70000; i++) step();
        chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
        flush = 1'b1;
        step(); chk("stall_flush", 64'(stall_cnt), 64'hFFFF);
        expect_out("stall_fl", 1'b0, 32'h0, 1'b1);
        flush = 1'b0;
`endif

        // W=8 random handshake stream; ordering is checked by the model every cycle.
        for (int unsigned i = 0; i < 10000; i++) begin
            in_valid8  = 1'($urandom_range(0, 1));
            out_ready8 = 1'($urandom_range(0, 1));
            in_data8   = 8'($urandom);
            step();
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        step(); step(); step();
        chk("r8_drained", 64'(out_valid8), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
